// File: rtl/pcap_replay_sched.sv
// Per-queue replay sequencer: gates the FIFO->TX AXI-S stream on packet boundaries, counts packets/passes
// and requests memory rewinds between passes. Define REPLAY_IPG_EN for the inter-packet gap (ipg_cycles).
module pcap_replay_sched #(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned CNT_WIDTH          = 32
) (
  input  logic                           axis_aclk,
  input  logic                           sw_rst,
  input  logic                           start,
  input  logic                           stop,
  input  logic [CNT_WIDTH-1:0]           replay_cnt,
  input  logic [CNT_WIDTH-1:0]           pkts_per_pass,
`ifdef REPLAY_IPG_EN
  input  logic [CNT_WIDTH-1:0]           ipg_cycles,
`endif
  input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  output logic                           s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready,
  output logic                           rewind_req,
  input  logic                           rewind_ack,
  output logic                           busy,
  output logic                           done,
  output logic [CNT_WIDTH-1:0]           pass_cnt,
  output logic [CNT_WIDTH-1:0]           pkt_cnt
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  typedef enum logic [2:0] {StIdle, StRun, StRewind, StDone, StGap} state_e;

  state_e               state_q, state_d;
  logic                 in_pkt_q, in_pkt_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 rewind_req_q, rewind_req_d;
  logic [CNT_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0] replay_cnt_q, replay_cnt_d;
  logic [CNT_WIDTH-1:0] pkts_per_pass_q, pkts_per_pass_d;
`ifdef REPLAY_IPG_EN
  logic [CNT_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic                 gap_rewind_q, gap_rewind_d;
`endif

  logic gate_open;
  logic beat_acc;

  assign gate_open     = (state_q == StRun);
  assign beat_acc      = gate_open & s_axis_tvalid & m_axis_tready;

  assign s_axis_tready = gate_open & m_axis_tready;
  assign m_axis_tvalid = gate_open & s_axis_tvalid;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign rewind_req = rewind_req_q;
  assign pass_cnt   = pass_cnt_q;
  assign pkt_cnt    = pkt_cnt_q;

  always_comb begin
    state_d         = state_q;
    in_pkt_d        = in_pkt_q;
    stop_pend_d     = stop_pend_q;
    pass_cnt_d      = pass_cnt_q;
    pkt_cnt_d       = pkt_cnt_q;
    replay_cnt_d    = replay_cnt_q;
    pkts_per_pass_d = pkts_per_pass_q;
`ifdef REPLAY_IPG_EN
    gap_cnt_d       = gap_cnt_q;
    gap_rewind_d    = gap_rewind_q;
`endif

    case (state_q)
      StIdle: begin
        if (start && !stop) begin
          if (replay_cnt == '0 || pkts_per_pass == '0) begin
            state_d = StDone;
          end else begin
            replay_cnt_d    = replay_cnt;
            pkts_per_pass_d = pkts_per_pass;
            pass_cnt_d      = '0;
            pkt_cnt_d       = '0;
            stop_pend_d     = 1'b0;
            state_d         = StRun;
          end
        end
      end

      StRun: begin
        if (stop) stop_pend_d = 1'b1;
        if (beat_acc) begin
          in_pkt_d = !s_axis_tlast;
          if (s_axis_tlast) begin
            if (stop_pend_q || stop) begin
              pkt_cnt_d = pkt_cnt_q + CntOne;
              state_d   = StDone;
            end else if (pkt_cnt_q + CntOne == pkts_per_pass_q) begin
              pkt_cnt_d  = '0;
              pass_cnt_d = pass_cnt_q + CntOne;
              state_d    = (pass_cnt_q + CntOne == replay_cnt_q) ? StDone : StRewind;
            end else begin
              pkt_cnt_d = pkt_cnt_q + CntOne;
            end
          end
        end else if ((stop || stop_pend_q) && !in_pkt_q) begin
          // Only stop between packets; mid-packet stops wait for tlast.
          state_d = StDone;
        end
      end

      StRewind: begin
        if (stop) stop_pend_d = 1'b1;
        if (rewind_ack) state_d = (stop_pend_q || stop) ? StDone : StRun;
      end

`ifdef REPLAY_IPG_EN
      StGap: begin
        if (stop) stop_pend_d = 1'b1;
        gap_cnt_d = gap_cnt_q - CntOne;
        if (gap_cnt_q == CntOne) begin
          if (stop_pend_q || stop) state_d = StDone;
          else                     state_d = gap_rewind_q ? StRewind : StRun;
        end
      end
`endif

      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

`ifdef REPLAY_IPG_EN
    // Packet finished without ending the run: insert the gap before resuming or rewinding.
    if (state_q == StRun && beat_acc && s_axis_tlast && state_d != StDone &&
        ipg_cycles != '0) begin
      gap_cnt_d    = ipg_cycles;
      gap_rewind_d = (state_d == StRewind);
      state_d      = StGap;
    end
`endif
  end

  assign rewind_req_d = (state_d == StRewind);

  always_ff @(posedge axis_aclk) begin
    if (sw_rst) begin
      state_q         <= StIdle;
      in_pkt_q        <= 1'b0;
      stop_pend_q     <= 1'b0;
      rewind_req_q    <= 1'b0;
      pass_cnt_q      <= '0;
      pkt_cnt_q       <= '0;
      replay_cnt_q    <= '0;
      pkts_per_pass_q <= '0;
`ifdef REPLAY_IPG_EN
      gap_cnt_q       <= '0;
      gap_rewind_q    <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      in_pkt_q        <= in_pkt_d;
      stop_pend_q     <= stop_pend_d;
      rewind_req_q    <= rewind_req_d;
      pass_cnt_q      <= pass_cnt_d;
      pkt_cnt_q       <= pkt_cnt_d;
      replay_cnt_q    <= replay_cnt_d;
      pkts_per_pass_q <= pkts_per_pass_d;
`ifdef REPLAY_IPG_EN
      gap_cnt_q       <= gap_cnt_d;
      gap_rewind_q    <= gap_rewind_d;
`endif
    end
  end

endmodule

// File: tb/tb_pcap_replay_sched.sv
// Bench for pcap_replay_sched: directed runs plus randomized traffic against a packet-level model.
// Define REPLAY_IPG_EN to also exercise the inter-packet gap.
module tb_pcap_replay_sched;
  localparam int DW = 256;
  localparam int UW = 128;
  localparam int CW = 32;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          sw_rst, start, stop;
  logic [CW-1:0] replay_cnt, pkts_per_pass;
`ifdef REPLAY_IPG_EN
  logic [CW-1:0] ipg_cycles;
`endif
  logic [DW-1:0] s_axis_tdata, m_axis_tdata;
  logic [KW-1:0] s_axis_tkeep, m_axis_tkeep;
  logic [UW-1:0] s_axis_tuser, m_axis_tuser;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic          rewind_req, rewind_ack, busy, done;
  logic [CW-1:0] pass_cnt, pkt_cnt;

  always #5 clk = ~clk;

  pcap_replay_sched #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(UW),
    .CNT_WIDTH         (CW)
  ) dut (
    .axis_aclk    (clk),
    .sw_rst       (sw_rst),
    .start        (start),
    .stop         (stop),
    .replay_cnt   (replay_cnt),
    .pkts_per_pass(pkts_per_pass),
`ifdef REPLAY_IPG_EN
    .ipg_cycles   (ipg_cycles),
`endif
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .rewind_req   (rewind_req),
    .rewind_ack   (rewind_ack),
    .busy         (busy),
    .done         (done),
    .pass_cnt     (pass_cnt),
    .pkt_cnt      (pkt_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  beat_t src[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    in_idx, out_idx, done_cnt, done_cyc, start_cyc, tlast_cyc, ack_cyc;
  int    rewind_cnt, req_len, req_total, last_req_len, ack_delay, stop_beat, gap_first;
  int    rdy_pct, vld_pct;
  bit    stop_on_req, ack_seen, acc_in, acc_out;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    if (!s_axis_tvalid || acc_in) begin
      if (in_idx < src.size() && $urandom_range(99) < vld_pct) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = src[in_idx].data;
        s_axis_tkeep  = src[in_idx].keep;
        s_axis_tuser  = src[in_idx].user;
        s_axis_tlast  = src[in_idx].last;
      end else begin
        s_axis_tvalid = 1'b0;
      end
    end
  endtask

  // One clock: observe at negedge, react (ack/stop) there, update drives 1 time unit after posedge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    acc_in  = s_axis_tvalid && s_axis_tready;
    acc_out = m_axis_tvalid && m_axis_tready;
    chk("lockstep", 256'(acc_out), 256'(acc_in));
    if (m_axis_tvalid) chk("tready_follow", 256'(s_axis_tready), 256'(m_axis_tready));
    if (!busy) chk("idle_closed", 256'({s_axis_tready, m_axis_tvalid}), 256'(0));
    if (acc_out) begin
      if (out_idx < src.size()) begin
        chk("tdata", m_axis_tdata, src[out_idx].data);
        chk("tkeep", 256'(m_axis_tkeep), 256'(src[out_idx].keep));
        chk("tuser", 256'(m_axis_tuser), 256'(src[out_idx].user));
        chk("tlast", 256'(m_axis_tlast), 256'(src[out_idx].last));
        if (out_idx > 0 && gap_first < 0 && src[out_idx-1].last) gap_first = cyc - tlast_cyc - 1;
      end else begin
        chk("extra_beat", 256'(out_idx), 256'(src.size()));
      end
      if (m_axis_tlast) tlast_cyc = cyc;
      out_idx++;
      if (out_idx == stop_beat) stop = 1'b1;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ack_seen) begin
      chk("req_drop", 256'(rewind_req), 256'(0));
      ack_seen = 1'b0;
    end
    if (rewind_req) begin
      req_len++;
      req_total++;
      if (stop_on_req && req_len == 1) stop = 1'b1;
      if (req_len == ack_delay) begin
        rewind_ack = 1'b1;
        ack_cyc    = cyc;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    if (rewind_ack) begin
      rewind_ack   = 1'b0;
      ack_seen     = 1'b1;
      rewind_cnt++;
      last_req_len = req_len;
      req_len      = 0;
    end
    if (acc_in) in_idx++;
    drive_src();
    m_axis_tready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic run(input int r, input int p, input int npk, input int minlen, input int maxlen,
                     input int rp, input int vp, input int ad, input int sb, input bit sreq);
    src.delete();
    for (int k = 0; k < npk; k++) begin
      int len;
      len = $urandom_range(maxlen, minlen);
      for (int b = 0; b < len; b++) begin
        beat_t bt;
        for (int w = 0; w < DW / 32; w++) bt.data[w*32 +: 32] = $urandom();
        for (int w = 0; w < UW / 32; w++) bt.user[w*32 +: 32] = $urandom();
        bt.keep = $urandom();
        bt.last = (b == len - 1);
        src.push_back(bt);
      end
    end
    in_idx = 0; out_idx = 0; done_cnt = 0; done_cyc = -1; tlast_cyc = -1; ack_cyc = -1;
    rewind_cnt = 0; req_len = 0; req_total = 0; last_req_len = 0; gap_first = -1;
    rdy_pct = rp; vld_pct = vp; ack_delay = ad; stop_beat = sb; stop_on_req = sreq;
    acc_in = 1'b0; s_axis_tvalid = 1'b0;
    drive_src();
    m_axis_tready = ($urandom_range(99) < rdy_pct);
    replay_cnt    = CW'(r);
    pkts_per_pass = CW'(p);
    start         = 1'b1;
    start_cyc     = cyc + 1;
    for (int i = 0; i < 3000 && done_cnt == 0; i++) tick();
    repeat (8) tick();
  endtask

  // Model: a run forwards whole packets in source order; n_pkts is how many it should deliver.
  function automatic int beats_of(input int n_pkts);
    int n = 0;
    int pk = 0;
    for (int i = 0; i < src.size() && pk < n_pkts; i++) begin
      n++;
      if (src[i].last) pk++;
    end
    return n;
  endfunction

  task automatic check_end(input int n_pkts, input int ep, input int ek, input int er);
    chk("fwd_beats", 256'(out_idx), 256'(beats_of(n_pkts)));
    chk("src_beats", 256'(in_idx), 256'(beats_of(n_pkts)));
    chk("pass_cnt", 256'(pass_cnt), 256'(ep));
    chk("pkt_cnt", 256'(pkt_cnt), 256'(ek));
    chk("rewinds", 256'(rewind_cnt), 256'(er));
    chk("done_pulses", 256'(done_cnt), 256'(1));
    chk("busy_end", 256'(busy), 256'(0));
  endtask

  initial begin
    sw_rst = 1'b1; start = 1'b0; stop = 1'b0; rewind_ack = 1'b0;
    replay_cnt = '0; pkts_per_pass = '0;
`ifdef REPLAY_IPG_EN
    ipg_cycles = '0;
`endif
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0; s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_req", 256'(rewind_req), 256'(0));
    chk("rst_pass", 256'(pass_cnt), 256'(0));
    chk("rst_pkt", 256'(pkt_cnt), 256'(0));
    chk("rst_s_tready", 256'(s_axis_tready), 256'(0));
    chk("rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
    @(posedge clk);
    #1;
    sw_rst = 1'b0;

    // Two passes of three 3-beat packets, full throughput.
    run(2, 3, 8, 3, 3, 100, 100, 2, -1, 1'b0);
    check_end(6, 2, 0, 1);

    // Stop on beat 2 of the second 4-beat packet: that packet completes, then done.
    run(2, 5, 6, 4, 4, 100, 100, 2, 6, 1'b0);
    check_end(2, 0, 2, 0);
    chk("done_after_tlast", 256'(done_cyc - tlast_cyc), 256'(1));

    // Zero passes: immediate done, nothing forwarded, no rewind.
    run(0, 3, 3, 1, 3, 100, 100, 1, -1, 1'b0);
    chk("zero_beats", 256'(out_idx), 256'(0));
    chk("zero_done_lat", 256'(done_cyc - start_cyc), 256'(1));
    chk("zero_req", 256'(req_total), 256'(0));
    chk("zero_pulses", 256'(done_cnt), 256'(1));

    // Stop during a slow rewind: handshake completes, then the run ends.
    run(3, 1, 4, 1, 3, 100, 100, 10, -1, 1'b1);
    check_end(1, 1, 0, 1);
    chk("req_held", 256'(last_req_len), 256'(10));
    chk("done_after_ack", 256'(done_cyc - ack_cyc), 256'(1));

    // Random backpressure, source gaps and packet lengths.
    for (int it = 0; it < 4; it++) begin
      int r, p;
      r = $urandom_range(3, 1);
      p = $urandom_range(3, 1);
      run(r, p, r * p + 2, 1, 4, 50, 70, $urandom_range(5, 1), -1, 1'b0);
      check_end(r * p, r, 0, r - 1);
    end

`ifdef REPLAY_IPG_EN
    ipg_cycles = CW'(5);
    run(1, 3, 4, 2, 2, 100, 100, 1, -1, 1'b0);
    check_end(3, 1, 0, 0);
    chk("ipg_gap5", 256'(gap_first), 256'(5));
    ipg_cycles = '0;
    run(1, 3, 4, 2, 2, 100, 100, 1, -1, 1'b0);
    check_end(3, 1, 0, 0);
    chk("ipg_gap0", 256'(gap_first), 256'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
